control_seq: RTL and testbench
==============================

Name: control_seq

Overview:
- Sequenced successor to the combinational opcode decoder: registered decode stage with valid/ready handshakes on both sides.
- Adds memory wait-state sequencing for load/store and branch-flush squashing; parametrised in opcode width and latencies.
- Sits between fetch (upstream) and register file/ALU/memory (downstream) and drives their control lines for one instruction per accepted handshake.

Parameters:
- OPC_W, 5, opcode width (≥5); bits [OPC_W-1:5] must be zero, otherwise the opcode is illegal.
- MEM_LAT, 2, extra stall cycles after a lb/sb is accepted (0 = none).
- FLUSH_LEN, 2, number of upstream instructions discarded after branch_taken (≥1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream opcode valid.
- in_ready  out  1  stage accepts opcode this cycle.
- opcode  in  OPC_W  instruction opcode.
- branch_taken  in  1  single-cycle pulse from execute: branch/jump resolved taken.
- out_valid  out  1  registered control bundle valid.
- out_ready  in  1  downstream consumes bundle.
- alu_mode  out  3  ALU_MODE_* code.
- rf_write_en  out  1  register file write enable.
- rf_write_data_sel  out  1  1 = memory data (lb).
- rf_write_addr_sel  out  1  alternate write address.
- alu_a_sel  out  1  0 = accumulator, 1 = PC.
- alu_b_sel  out  1  0 = register, 1 = immediate.
- mem_write_en  out  1  sb.
- mem_read_en  out  1  lb.
- is_branch  out  1  opcode class 11xx.
- illegal  out  1  bundle came from an illegal opcode.
- retired_cnt  out  CNT_W  bundles consumed downstream.

Behaviour:
- Decode, with o = opcode[4:0]:
  - alu_mode:
    - o[4:1] = 000x → ADD
    - o[4:1] = 001x → SHIFT
    - 0100 → NOT
    - 0101 → AND
    - 0110 → OR
    - 0111 → XOR
    - 10xx → BYPASS_A
    - 11xx → ADD
  - rf_write_en = !o[4] | (o[4:2] == 100).
  - rf_write_data_sel = (o[4:1] == 1001).
  - rf_write_addr_sel = (o[4:2] == 100).
  - alu_a_sel = (o[4:3] == 11) | (o == 10001).
  - alu_b_sel = (o[4:3] == 11) | (o[4:3] == 00 & o[1]).
  - mem_write_en = (o[4:1] == 1010).
  - mem_read_en = (o[4:1] == 1001).
  - is_branch = (o[4:3] == 11).
- Illegal opcode: every enable (rf_write_en, mem_write_en, mem_read_en) = 0, alu_mode = ADD, other selects 0, illegal = 1. The bundle is still issued.
- Enable gating: rf_write_en, mem_write_en and mem_read_en are 0 whenever out_valid = 0.
- States: RUN, MEM_WAIT, FLUSH.
- RUN:
  - in_ready = !out_valid | out_ready.
  - Accept (in_valid & in_ready) → bundle registered, out_valid = 1 next cycle (latency 1).
  - If the accepted opcode is lb/sb and MEM_LAT > 0 → MEM_WAIT, wait_cnt = MEM_LAT.
- MEM_WAIT:
  - in_ready = 0; wait_cnt decrements each cycle.
  - In the cycle wait_cnt == 1 → RUN.
  - The output handshake proceeds independently.
- FLUSH:
  - Entered the cycle after branch_taken = 1 from any state, with flush_cnt = FLUSH_LEN.
  - In the branch_taken cycle itself: any input accept is discarded, and out_valid clears next cycle.
  - In FLUSH: in_ready = 1, each in_valid handshake is discarded and decrements flush_cnt, no output is produced.
  - At 0 → RUN.
- Priority: rst_n > branch_taken > MEM_WAIT/accept.
  - branch_taken during MEM_WAIT abandons the wait.
  - branch_taken during FLUSH reloads flush_cnt = FLUSH_LEN.
- Output hold: out_valid & !out_ready holds the bundle stable.
- Retired counter: retired_cnt increments on out_valid & out_ready and wraps modulo 2^CNT_W. The bundle being killed by a flush does not count.
- Reset: rst_n = 0 at a clock edge → state RUN, all counters 0, out_valid 0, every bundle output 0, retired_cnt 0. in_ready is low during reset and 1 in the first cycle after reset.

Decomposition:
- Shared package (control_pkg):
  - ALU_MODE_ADD/SHIFT/NOT/AND/OR/XOR/BYPASS_A codes.
  - Opcode class constants (LB = 1001, SB = 1010, BRANCH = 11).
  - State encoding (RUN, MEM_WAIT, FLUSH).
  - Control-bundle struct.
- Sub-module control_decode: purely combinational opcode → bundle, including the illegal check, instantiated once.

Test Plan:
- Reset, then add (00000) with out_ready = 1 → next cycle out_valid = 1, alu_mode = ADD, rf_write_en = 1, alu_b_sel = 0; retired_cnt = 1 one cycle later.
- lb (10010), MEM_LAT = 2, in_valid held high → in_ready low for 2 cycles after accept; rf_write_data_sel = 1, mem_read_en = 1; the next opcode is accepted on the 3rd cycle.
- Backpressure: out_ready = 0 for 3 cycles after an xor (01110) issue → bundle stable, in_ready = 0, retired_cnt unchanged; on release, retired_cnt +1.
- branch_taken pulse with FLUSH_LEN = 2 and a continuous opcode stream → the in-flight bundle is killed (out_valid = 0), the next 2 accepted opcodes produce no output, the 3rd issues normally.
- OPC_W = 7, opcode 7'b0100000 → illegal = 1, all enables 0, out_valid = 1.
- rst_n low mid-MEM_WAIT → next cycle state RUN, all outputs 0; after release, in_ready = 1.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the sequenced control stage: ALU mode codes,
// opcode class patterns, FSM state encoding and the control bundle.
package control_pkg;

    localparam int unsigned ALU_MODE_W = 3;

    // ALU mode codes driven on alu_mode
    localparam logic [ALU_MODE_W-1:0] ALU_MODE_ADD      = 3'd0;
    localparam logic [ALU_MODE_W-1:0] ALU_MODE_SHIFT    = 3'd1;
    localparam logic [ALU_MODE_W-1:0] ALU_MODE_NOT      = 3'd2;
    localparam logic [ALU_MODE_W-1:0] ALU_MODE_AND      = 3'd3;
    localparam logic [ALU_MODE_W-1:0] ALU_MODE_OR       = 3'd4;
    localparam logic [ALU_MODE_W-1:0] ALU_MODE_XOR      = 3'd5;
    localparam logic [ALU_MODE_W-1:0] ALU_MODE_BYPASS_A = 3'd6;

    // Opcode class patterns: LB/SB match o[4:1], BRANCH matches o[4:3]
    localparam logic [3:0] OPC_CLASS_LB     = 4'b1001;
    localparam logic [3:0] OPC_CLASS_SB     = 4'b1010;
    localparam logic [1:0] OPC_CLASS_BRANCH = 2'b11;

    // Sequencer state encoding
    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
    localparam logic [ST_W-1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_FLUSH    = 2'd2;

    // Control lines issued downstream for one instruction
    typedef struct packed {
        logic [ALU_MODE_W-1:0] alu_mode;
        logic                  rf_write_en;
        logic                  rf_write_data_sel;
        logic                  rf_write_addr_sel;
        logic                  alu_a_sel;
        logic                  alu_b_sel;
        logic                  mem_write_en;
        logic                  mem_read_en;
        logic                  is_branch;
        logic                  illegal;
    } ctrl_bundle_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder producing one control bundle.
// Ports:
//   opcode - instruction opcode, bits above [4] must be zero to be legal
//   bundle - decoded control lines, forced to a safe pattern when illegal
module control_decode
    import control_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_bundle_t     bundle
);

    logic [4:0] o;
    logic       hi_nz;

    assign o = opcode[4:0];

    // Any set bit above the 5-bit base opcode makes the opcode illegal
    generate
        if (OPC_W > 5) begin : g_ext
            assign hi_nz = |opcode[OPC_W-1:5];
        end else begin : g_base
            assign hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        bundle = '0;

        casez (o[4:1])
            4'b000?: bundle.alu_mode = ALU_MODE_ADD;
            4'b001?: bundle.alu_mode = ALU_MODE_SHIFT;
            4'b0100: bundle.alu_mode = ALU_MODE_NOT;
            4'b0101: bundle.alu_mode = ALU_MODE_AND;
            4'b0110: bundle.alu_mode = ALU_MODE_OR;
            4'b0111: bundle.alu_mode = ALU_MODE_XOR;
            4'b10??: bundle.alu_mode = ALU_MODE_BYPASS_A;
            default: bundle.alu_mode = ALU_MODE_ADD;
        endcase

        bundle.rf_write_en       = !o[4] || (o[4:2] == 3'b100);
        bundle.rf_write_data_sel = (o[4:1] == OPC_CLASS_LB);
        bundle.rf_write_addr_sel = (o[4:2] == 3'b100);
        bundle.alu_a_sel         = (o[4:3] == OPC_CLASS_BRANCH) || (o == 5'b10001);
        bundle.alu_b_sel         = (o[4:3] == OPC_CLASS_BRANCH) || ((o[4:3] == 2'b00) && o[1]);
        bundle.mem_write_en      = (o[4:1] == OPC_CLASS_SB);
        bundle.mem_read_en       = (o[4:1] == OPC_CLASS_LB);
        bundle.is_branch         = (o[4:3] == OPC_CLASS_BRANCH);

        // Illegal opcodes still issue, but with every enable and select cleared
        if (hi_nz) begin
            bundle          = '0;
            bundle.alu_mode = ALU_MODE_ADD;
            bundle.illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/control_seq.sv
// Registered decode stage with valid/ready on both sides, memory wait-state
// sequencing for lb/sb and squashing of upstream instructions after a taken
// branch. Ports:
//   clk, rst_n         - clock and synchronous active-low reset
//   in_valid/in_ready  - upstream opcode handshake (in_ready is combinational)
//   opcode             - instruction opcode
//   branch_taken       - single-cycle pulse: kill in-flight work and flush
//   out_valid/out_ready- downstream bundle handshake
//   alu_mode .. illegal- registered control bundle, enables zero when idle
//   retired_cnt        - count of bundles consumed downstream (wraps)
module control_seq
    import control_pkg::*;
#(
    parameter int unsigned OPC_W     = 5,
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPC_W-1:0]      opcode,
    input  logic                  branch_taken,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_MODE_W-1:0] alu_mode,
    output logic                  rf_write_en,
    output logic                  rf_write_data_sel,
    output logic                  rf_write_addr_sel,
    output logic                  alu_a_sel,
    output logic                  alu_b_sel,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic                  is_branch,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retired_cnt
);

    localparam int unsigned WAIT_W  = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int unsigned FLUSH_W = $clog2(FLUSH_LEN + 1);

    logic [ST_W-1:0]    state_q,     state_d;
    logic [WAIT_W-1:0]  wait_q,      wait_d;
    logic [FLUSH_W-1:0] flush_q,     flush_d;
    ctrl_bundle_t       bundle_q,    bundle_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   retired_q,   retired_d;

    ctrl_bundle_t       dec_bundle;
    logic               in_ready_c;
    logic               accept_c;
    logic               consume_c;
    logic               mem_op_c;

    control_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode (opcode),
        .bundle (dec_bundle)
    );

    // Upstream readiness: held low in reset, stalled during memory wait,
    // always open while flushing so discarded instructions drain
    always_comb begin
        in_ready_c = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_RUN:   in_ready_c = !out_valid_q || out_ready;
                ST_FLUSH: in_ready_c = 1'b1;
                default:  in_ready_c = 1'b0;
            endcase
        end
    end

    assign accept_c  = in_valid && in_ready_c;
    assign consume_c = out_valid_q && out_ready;
    assign mem_op_c  = dec_bundle.mem_read_en || dec_bundle.mem_write_en;

    // Next-state, bundle and counter logic
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        flush_d     = flush_q;
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        retired_d   = retired_q;

        // A bundle killed by a taken branch is not counted as retired
        if (consume_c && !branch_taken) begin
            retired_d = retired_q + CNT_W'(1);
        end

        // Clearing the bundle on drain keeps enables low whenever out_valid is low
        if (consume_c) begin
            out_valid_d = 1'b0;
            bundle_d    = '0;
        end

        if (branch_taken) begin
            state_d     = ST_FLUSH;
            flush_d     = FLUSH_W'(FLUSH_LEN);
            wait_d      = '0;
            out_valid_d = 1'b0;
            bundle_d    = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept_c) begin
                        bundle_d    = dec_bundle;
                        out_valid_d = 1'b1;
                        if (mem_op_c && (MEM_LAT > 0)) begin
                            state_d = ST_MEM_WAIT;
                            wait_d  = WAIT_W'(MEM_LAT);
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    wait_d = wait_q - WAIT_W'(1);
                    if (wait_q == WAIT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // Each handshake here is swallowed; leave once the count hits zero
                    if (accept_c) begin
                        flush_d = flush_q - FLUSH_W'(1);
                        if (flush_q == FLUSH_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            flush_q     <= '0;
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            flush_q     <= flush_d;
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            retired_q   <= retired_d;
        end
    end

    assign in_ready          = in_ready_c;
    assign out_valid         = out_valid_q;
    assign alu_mode          = bundle_q.alu_mode;
    assign rf_write_en       = bundle_q.rf_write_en;
    assign rf_write_data_sel = bundle_q.rf_write_data_sel;
    assign rf_write_addr_sel = bundle_q.rf_write_addr_sel;
    assign alu_a_sel         = bundle_q.alu_a_sel;
    assign alu_b_sel         = bundle_q.alu_b_sel;
    assign mem_write_en      = bundle_q.mem_write_en;
    assign mem_read_en       = bundle_q.mem_read_en;
    assign is_branch         = bundle_q.is_branch;
    assign illegal           = bundle_q.illegal;
    assign retired_cnt       = retired_q;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq with a bundle scoreboard.
module tb_control_seq;
    import control_pkg::*;

    localparam int unsigned OPC_W     = 7;
    localparam int unsigned MEM_LAT   = 2;
    localparam int unsigned FLUSH_LEN = 2;
    localparam int unsigned CNT_W     = 4;

    localparam logic [OPC_W-1:0] OP_ADD   = 7'b0000000;
    localparam logic [OPC_W-1:0] OP_LB    = 7'b0010010;
    localparam logic [OPC_W-1:0] OP_SB    = 7'b0010100;
    localparam logic [OPC_W-1:0] OP_XOR   = 7'b0001110;
    localparam logic [OPC_W-1:0] OP_OR    = 7'b0001100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_ILL   = 7'b0100000;
    localparam logic [OPC_W-1:0] OP_ILLLB = 7'b1010010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [OPC_W-1:0] opcode;
    logic             branch_taken;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       alu_mode;
    logic             rf_write_en;
    logic             rf_write_data_sel;
    logic             rf_write_addr_sel;
    logic             alu_a_sel;
    logic             alu_b_sel;
    logic             mem_write_en;
    logic             mem_read_en;
    logic             is_branch;
    logic             illegal;
    logic [CNT_W-1:0] retired_cnt;

    int               n_checks = 0;
    int               n_fail   = 0;
    ctrl_bundle_t     exp_q[$];
    logic [CNT_W-1:0] exp_retired = '0;

    control_seq #(
        .OPC_W     (OPC_W),
        .MEM_LAT   (MEM_LAT),
        .FLUSH_LEN (FLUSH_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .opcode            (opcode),
        .branch_taken      (branch_taken),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .alu_mode          (alu_mode),
        .rf_write_en       (rf_write_en),
        .rf_write_data_sel (rf_write_data_sel),
        .rf_write_addr_sel (rf_write_addr_sel),
        .alu_a_sel         (alu_a_sel),
        .alu_b_sel         (alu_b_sel),
        .mem_write_en      (mem_write_en),
        .mem_read_en       (mem_read_en),
        .is_branch         (is_branch),
        .illegal           (illegal),
        .retired_cnt       (retired_cnt)
    );

    always #5 clk = ~clk;

    // Reference decode written from the opcode table
    function automatic ctrl_bundle_t model_decode(input logic [OPC_W-1:0] op);
        ctrl_bundle_t b;
        logic [4:0]   o;
        b = '0;
        o = op[4:0];
        if (op[OPC_W-1:5] != '0) begin
            b.illegal = 1'b1;
            return b;
        end
        if (o[4:2] == 3'b000)      b.alu_mode = 3'd0;
        else if (o[4:2] == 3'b001) b.alu_mode = 3'd1;
        else if (o[4:3] == 2'b01)  b.alu_mode = 3'd2 + 3'(o[2:1]);
        else if (o[4:3] == 2'b10)  b.alu_mode = 3'd6;
        else                       b.alu_mode = 3'd0;
        b.rf_write_en       = !o[4] | (o[4:2] == 3'b100);
        b.rf_write_data_sel = (o[4:1] == 4'b1001);
        b.rf_write_addr_sel = (o[4:2] == 3'b100);
        b.alu_a_sel         = (o[4:3] == 2'b11) | (o == 5'b10001);
        b.alu_b_sel         = (o[4:3] == 2'b11) | ((o[4:3] == 2'b00) & o[1]);
        b.mem_write_en      = (o[4:1] == 4'b1010);
        b.mem_read_en       = (o[4:1] == 4'b1001);
        b.is_branch         = (o[4:3] == 2'b11);
        return b;
    endfunction

    // Gather the DUT bundle ports into one value
    function automatic ctrl_bundle_t obs();
        ctrl_bundle_t b;
        b.alu_mode          = alu_mode;
        b.rf_write_en       = rf_write_en;
        b.rf_write_data_sel = rf_write_data_sel;
        b.rf_write_addr_sel = rf_write_addr_sel;
        b.alu_a_sel         = alu_a_sel;
        b.alu_b_sel         = alu_b_sel;
        b.mem_write_en      = mem_write_en;
        b.mem_read_en       = mem_read_en;
        b.is_branch         = is_branch;
        b.illegal           = illegal;
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; opcode = OP_ADD; branch_taken = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || retired_cnt !== '0 || obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b cnt=%0d bundle=%h, required 0 0 0 000",
                     in_ready, out_valid, retired_cnt, obs());
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        ctrl_bundle_t e;
        opcode = OP_ADD; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b required 1", in_ready); end
        exp_q.push_back(model_decode(opcode));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (out_valid !== 1'b1 || obs() !== e) begin
            n_fail++; $display("FAIL add_bundle: valid=%b got %h required %h", out_valid, obs(), e);
        end
        n_checks++;
        if (alu_mode !== 3'd0 || rf_write_en !== 1'b1 || alu_b_sel !== 1'b0) begin
            n_fail++; $display("FAIL add_fields: mode=%0d we=%b bsel=%b required 0 1 0", alu_mode, rf_write_en, alu_b_sel);
        end
        exp_retired++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (retired_cnt !== exp_retired) begin
            n_fail++; $display("FAIL add_retired: got %0d required %0d", retired_cnt, exp_retired);
        end
        n_checks++;
        if (out_valid !== 1'b0 || rf_write_en !== 1'b0) begin
            n_fail++; $display("FAIL add_idle_gating: valid=%b we=%b required 0 0", out_valid, rf_write_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lb_wait();
        ctrl_bundle_t e;
        opcode = OP_LB; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_accept_ready: got %b required 1", in_ready); end
        exp_q.push_back(model_decode(opcode));
        @(posedge clk); #1 opcode = OP_ADDI;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_stall1: in_ready got %b required 0", in_ready); end
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (out_valid !== 1'b1 || obs() !== e || rf_write_data_sel !== 1'b1 || mem_read_en !== 1'b1) begin
            n_fail++; $display("FAIL lb_bundle: valid=%b got %h required %h", out_valid, obs(), e);
        end
        exp_retired++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_stall2: in_ready got %b required 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0 || mem_read_en !== 1'b0) begin
            n_fail++; $display("FAIL lb_gating: valid=%b mem_read_en=%b required 0 0", out_valid, mem_read_en);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_resume: in_ready got %b required 1", in_ready); end
        exp_q.push_back(model_decode(opcode));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (out_valid !== 1'b1 || obs() !== e) begin
            n_fail++; $display("FAIL lb_next_bundle: valid=%b got %h required %h", out_valid, obs(), e);
        end
        exp_retired++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        ctrl_bundle_t e;
        ctrl_bundle_t xor_b;
        opcode = OP_XOR; in_valid = 1'b1; out_ready = 1'b1;
        xor_b = model_decode(OP_XOR);
        @(negedge clk);
        exp_q.push_back(model_decode(opcode));
        @(posedge clk); #1 out_ready = 1'b0; opcode = OP_ADD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || obs() !== xor_b || in_ready !== 1'b0 || retired_cnt !== exp_retired) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid=%b bundle=%h ready=%b cnt=%0d required 1 %h 0 %0d",
                         i, out_valid, obs(), in_ready, retired_cnt, xor_b, exp_retired);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (out_valid !== 1'b1 || obs() !== e) begin
            n_fail++; $display("FAIL bp_xor_bundle: valid=%b got %h required %h", out_valid, obs(), e);
        end
        exp_retired++;
        exp_q.push_back(model_decode(opcode));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (retired_cnt !== exp_retired) begin
            n_fail++; $display("FAIL bp_retired: got %0d required %0d", retired_cnt, exp_retired);
        end
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (out_valid !== 1'b1 || obs() !== e) begin
            n_fail++; $display("FAIL bp_next_bundle: valid=%b got %h required %h", out_valid, obs(), e);
        end
        exp_retired++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        ctrl_bundle_t e;
        opcode = OP_OR; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 branch_taken = 1'b1; opcode = OP_ADDI;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_inflight: valid got %b required 1", out_valid); end
        @(posedge clk); #1 branch_taken = 1'b0; opcode = OP_ADD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || rf_write_en !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_discard_%0d: valid=%b we=%b ready=%b required 0 0 1", i, out_valid, rf_write_en, in_ready);
            end
            @(posedge clk); #1 opcode = (i == 0) ? OP_LB : OP_XOR;
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_exit: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        exp_q.push_back(model_decode(opcode));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (out_valid !== 1'b1 || obs() !== e) begin
            n_fail++; $display("FAIL flush_third_issue: valid=%b got %h required %h", out_valid, obs(), e);
        end
        exp_retired++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (retired_cnt !== exp_retired) begin
            n_fail++; $display("FAIL flush_retired: got %0d required %0d", retired_cnt, exp_retired);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_branch_in_mem_wait();
        ctrl_bundle_t e;
        opcode = OP_SB; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 branch_taken = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || mem_write_en !== 1'b1) begin
            n_fail++; $display("FAIL bmw_wait: ready=%b valid=%b mem_we=%b required 0 1 1", in_ready, out_valid, mem_write_en);
        end
        @(posedge clk); #1 branch_taken = 1'b0; in_valid = 1'b1; opcode = OP_ADD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL bmw_flush_%0d: ready=%b valid=%b required 1 0", i, in_ready, out_valid);
            end
            @(posedge clk); #1 opcode = OP_OR;
        end
        @(negedge clk);
        exp_q.push_back(model_decode(opcode));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (out_valid !== 1'b1 || obs() !== e) begin
            n_fail++; $display("FAIL bmw_issue: valid=%b got %h required %h", out_valid, obs(), e);
        end
        exp_retired++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (retired_cnt !== exp_retired) begin
            n_fail++; $display("FAIL bmw_retired: got %0d required %0d", retired_cnt, exp_retired);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        ctrl_bundle_t e;
        opcode = OP_ILLLB; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        exp_q.push_back(model_decode(opcode));
        @(posedge clk); #1 opcode = OP_ILL;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL illegal_no_stall: in_ready got %b required 1", in_ready);
                end
                exp_q.push_back(model_decode(opcode));
            end
            n_checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            if (out_valid !== 1'b1 || obs() !== e || illegal !== 1'b1 || rf_write_en !== 1'b0 ||
                mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || alu_mode !== 3'd0) begin
                n_fail++; $display("FAIL illegal_bundle_%0d: valid=%b got %h required %h", i, out_valid, obs(), e);
            end
            exp_retired++;
            @(posedge clk); #1 in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_wait();
        opcode = OP_LB; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rmw_in_wait: ready=%b valid=%b required 0 1", in_ready, out_valid);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        exp_retired = '0;
        n_checks++;
        if (out_valid !== 1'b0 || obs() !== '0 || retired_cnt !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_after_reset: valid=%b bundle=%h cnt=%0d ready=%b required 0 000 0 1",
                     out_valid, obs(), retired_cnt, in_ready);
        end
        @(posedge clk); #1 out_ready = 1'b1;
    endtask

    // All legal opcodes (plus a wrap of the 4-bit counter) with random backpressure
    task automatic test_decode_sweep();
        ctrl_bundle_t e;
        ctrl_bundle_t prev_b;
        logic         held;
        int           idx;
        int           cyc;
        idx = 0; cyc = 0; held = 1'b0; prev_b = '0;
        in_valid = 1'b1; opcode = OP_ADD;
        while ((idx < 37 || exp_q.size() != 0 || out_valid) && cyc < 600) begin
            @(negedge clk);
            n_checks++;
            if (retired_cnt !== exp_retired) begin
                n_fail++; $display("FAIL sweep_retired: got %0d required %0d", retired_cnt, exp_retired);
            end
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || obs() !== prev_b) begin
                    n_fail++; $display("FAIL sweep_hold: valid=%b got %h required %h", out_valid, obs(), prev_b);
                end
            end
            held   = out_valid && !out_ready;
            prev_b = obs();
            if (out_valid && out_ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL sweep_bundle: got %h required %h", obs(), e);
                end
                exp_retired++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_decode(opcode));
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (idx < 37);
            opcode    = OPC_W'(idx % 32);
        end
        n_checks++;
        if (cyc >= 600 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL sweep_timeout: cycles=%0d pending=%0d required <600 0", cyc, exp_q.size());
        end
        @(negedge clk);
        n_checks++;
        if (retired_cnt !== exp_retired) begin
            n_fail++; $display("FAIL sweep_final_retired: got %0d required %0d", retired_cnt, exp_retired);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lb_wait();
        test_backpressure();
        test_flush();
        test_branch_in_mem_wait();
        test_illegal();
        test_reset_mid_wait();
        test_decode_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
